// File: rtl/frame_cycle_meter.sv
// frame_cycle_meter: measures the camera vsync period in ACLK cycles and
// counts frames; results feed the register slave's read-back registers.
// Ports: ACLK, ARESETN (async, active low), ctrl_en (level),
//   ctrl_clr (pulse), cam_vsync (async raw) -> period_cnt, frame_cnt,
//   period_valid (pulse), ovf (sticky), busy.
// Optional macro FRAME_CYCLE_METER_MINMAX_EN adds period_min/period_max.
module frame_cycle_meter #(
  parameter int CNT_W  = 32,
  parameter int FCNT_W = 16,
  parameter bit VS_POL = 1'b1
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              ctrl_en,
  input  logic              ctrl_clr,
  input  logic              cam_vsync,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              period_valid,
  output logic              ovf,
  output logic              busy
`ifdef FRAME_CYCLE_METER_MINMAX_EN
  ,
  output logic [CNT_W-1:0]  period_min,
  output logic [CNT_W-1:0]  period_max
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  state_t state, state_n;

  logic vs_s1, vs_s2, vs_s3, vs_edge;

  logic [CNT_W-1:0]  run_cnt, run_n;
  logic [CNT_W-1:0]  per_n;
  logic [FCNT_W-1:0] fcnt_n;
  logic              ovf_n, pv_n;
`ifdef FRAME_CYCLE_METER_MINMAX_EN
  logic [CNT_W-1:0]  min_n, max_n;
`endif

  // Two sync flops, one history flop, registered edge pulse:
  // the pulse appears 3 ACLK cycles after the raw transition.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      vs_s1   <= 1'b0;
      vs_s2   <= 1'b0;
      vs_s3   <= 1'b0;
      vs_edge <= 1'b0;
    end else begin
      vs_s1   <= cam_vsync;
      vs_s2   <= vs_s1;
      vs_s3   <= vs_s2;
      vs_edge <= VS_POL ? (vs_s2 & ~vs_s3)
                        : (~vs_s2 & vs_s3);
    end
  end

  always_comb begin
    state_n = state;
    run_n   = run_cnt;
    per_n   = period_cnt;
    fcnt_n  = frame_cnt;
    ovf_n   = ovf;
    pv_n    = 1'b0;
`ifdef FRAME_CYCLE_METER_MINMAX_EN
    min_n   = period_min;
    max_n   = period_max;
`endif
    if (ctrl_clr) begin
      per_n   = '0;
      fcnt_n  = '0;
      ovf_n   = 1'b0;
      run_n   = '0;
      state_n = ctrl_en ? ARM : IDLE;
`ifdef FRAME_CYCLE_METER_MINMAX_EN
      min_n   = '1;
      max_n   = '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (ctrl_en) state_n = ARM;
        end
        ARM: begin
          if (!ctrl_en) begin
            state_n = IDLE;
            run_n   = '0;
          end else if (vs_edge) begin
            state_n = MEASURE;
            run_n   = {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        MEASURE: begin
          if (!ctrl_en) begin
            state_n = IDLE;
            run_n   = '0;
          end else if (vs_edge) begin
            per_n  = run_cnt;
            run_n  = {{(CNT_W-1){1'b0}}, 1'b1};
            fcnt_n = frame_cnt + 1'b1;
            pv_n   = 1'b1;
`ifdef FRAME_CYCLE_METER_MINMAX_EN
            if (run_cnt < period_min) min_n = run_cnt;
            if (run_cnt > period_max) max_n = run_cnt;
`endif
          end else if (run_cnt == CNT_MAX) begin
            // Counter holds at max; the period is now too long.
            ovf_n = 1'b1;
          end else begin
            run_n = run_cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          run_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state        <= IDLE;
      run_cnt      <= '0;
      period_cnt   <= '0;
      frame_cnt    <= '0;
      ovf          <= 1'b0;
      period_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      run_cnt      <= run_n;
      period_cnt   <= per_n;
      frame_cnt    <= fcnt_n;
      ovf          <= ovf_n;
      period_valid <= pv_n;
      busy         <= (state_n != IDLE);
    end
  end

`ifdef FRAME_CYCLE_METER_MINMAX_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      period_min <= '1;
      period_max <= '0;
    end else begin
      period_min <= min_n;
      period_max <= max_n;
    end
  end
`endif

endmodule

// File: doc/frame_cycle_meter.md
Name: frame_cycle_meter

Overview:
- Measures the OV5640 frame period in ACLK cycles, and counts frames.
- Sits directly downstream of the cycle_num AXI-Lite register slave:
  - control bits (enable, clear) come from slave register 0;
  - results (period, frame count, status) are returned to the slave's read-back registers for software.
- Camera vsync is asynchronous to ACLK and is synchronised internally.

Parameters:
- CNT_W, 32, width of the period counter and period outputs (8..32).
- FCNT_W, 16, width of the frame counter.
- VS_POL, 1, vsync active polarity (1 = measure rising edges, 0 = measure falling edges).

Ports:
- ACLK  in  1  system clock; all logic on the rising edge.
- ARESETN  in  1  asynchronous active-low reset. Asserts immediately; release is sampled on ACLK.
- ctrl_en  in  1  level; 1 = measurement enabled.
- ctrl_clr  in  1  single-cycle pulse; clears all results.
- cam_vsync  in  1  raw OV5640 vsync, asynchronous.
- period_cnt  out  CNT_W  cycles between the last two qualifying vsync edges.
- frame_cnt  out  FCNT_W  number of completed periods, wraps modulo 2^FCNT_W.
- period_valid  out  1  one-cycle pulse when period_cnt updates.
- ovf  out  1  sticky flag: a period exceeded 2^CNT_W-1 cycles.
- busy  out  1  high in ARM and MEASURE.

Behaviour:
- Reset (ARESETN=0), all outputs and state:
  - period_cnt=0, frame_cnt=0, period_valid=0, ovf=0, busy=0;
  - synchroniser flops=0, run_cnt=0, state=IDLE.
- Input path:
  - vsync passes through a 2-flop synchroniser, then a registered edge detector.
  - edge is a one-cycle pulse, 3 ACLK cycles after the raw transition.
  - Edge polarity is selected by VS_POL.
- FSM states: IDLE, ARM, MEASURE.
  - IDLE: if ctrl_en=1, go to ARM next cycle.
  - ARM: wait for edge; on edge set run_cnt=1 and go to MEASURE. No period is reported for this first edge.
  - MEASURE, per cycle:
    - no edge: run_cnt increments. At 2^CNT_W-1 it saturates and sets ovf=1 (sticky).
    - edge: period_cnt<=run_cnt, run_cnt<=1, frame_cnt<=frame_cnt+1, period_valid=1 on the next cycle.
  - Period definition: edges in cycles t and t+N yield period_cnt=N.
  - ctrl_en=0 in ARM or MEASURE: go to IDLE next cycle. run_cnt is zeroed; period_cnt, frame_cnt and ovf are held.
- ctrl_clr has highest priority:
  - on its cycle: period_cnt=0, frame_cnt=0, ovf=0, run_cnt=0, no period_valid;
  - next state is ARM if ctrl_en=1, else IDLE;
  - an edge in the same cycle as ctrl_clr is discarded.
- Saturated period: an edge after saturation reports period_cnt=2^CNT_W-1; ovf stays 1 until clear or reset.
- frame_cnt wraps from 2^FCNT_W-1 to 0 with no flag.
- Glitches shorter than one ACLK period may be missed; no filtering is required.
- Outputs are fully registered; there are no combinational input-to-output paths.

Optional Feature:
- Macro: FRAME_CYCLE_METER_MINMAX_EN.
- When defined, two extra outputs are added: period_min and period_max, both out, CNT_W wide.
  - Reset/clear values: period_min = all ones, period_max = 0.
  - On each period update: period_min = min(current, new) and period_max = max(current, new), updated in the same cycle as period_cnt.
  - ctrl_en=0 holds both values.
- When not defined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset value check: assert ARESETN=0 mid-MEASURE with run_cnt=500 -> all outputs 0 immediately, state IDLE; after release there is no period_valid until two new edges.
- Basic period: ctrl_en=1, CNT_W=32, vsync rising every 1000 cycles for 4 edges -> period_valid pulses 3 times, period_cnt=1000 each time, frame_cnt=3, ovf=0.
- Clear priority: ctrl_clr pulsed in the same cycle as an edge, after frame_cnt=5 -> frame_cnt=0 and period_cnt=0, no valid pulse; the next period is reported only after two further edges.
- Saturation: CNT_W=8, edges 300 cycles apart -> period_cnt=255, ovf=1; later 100-cycle periods give period_cnt=100 with ovf still 1; ctrl_clr -> ovf=0.
- Disable mid-frame: ctrl_en dropped 400 cycles into a 1000-cycle frame -> busy=0 within 1 cycle, period_cnt and frame_cnt unchanged; re-enable -> ARM, first edge not reported.
- MINMAX_EN build: periods 800, 1200, 1000 -> period_min=800, period_max=1200; clear -> period_min=0xFFFFFFFF, period_max=0.
